// File: rtl/seg_scan_6.sv
// seg_scan_6 -- six-digit multiplexed driver for a common-anode 7-segment
// display, fed by the stopwatch core's packed-BCD minutes/seconds/10ms.
//
// Ports:
//   clk_core   in   1  system clock
//   rst        in   1  synchronous reset, active-high
//   min_i      in   8  minutes BCD   ([7:4] tens, [3:0] ones)
//   sec_i      in   8  seconds BCD
//   ms_10_i    in   8  10 ms units BCD
//   disp_en_i  in   1  0 forces the display dark; scanning keeps running
//   an_o       out  6  anode selects, active-low, bit5 = leftmost digit
//   seg_o      out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp_o       out  1  decimal point, active-low
//   frame_o    out  1  one-cycle pulse when a new snapshot is taken
//
// Each digit slot lasts SCAN_DIV cycles; the first BLANK_CYC cycles of a
// slot keep every anode off so the previous digit's segments never ghost
// onto the next anode. The three input bytes are captured together once per
// frame, so a frame never shows a mixture of old and new digits.

module seg_scan_6 #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 16,
  parameter bit          LZ_BLANK  = 1'b1
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic [7:0] min_i,
  input  logic [7:0] sec_i,
  input  logic [7:0] ms_10_i,
  input  logic       disp_en_i,
  output logic [5:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       frame_o
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] PCNT_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PCNT_BLANK = PW'(BLANK_CYC);

  // Digit slots, right to left on the display; the encoding doubles as the
  // anode bit number.
  typedef enum logic [2:0] {
    DIG_MS_ONES  = 3'd0,
    DIG_MS_TENS  = 3'd1,
    DIG_SEC_ONES = 3'd2,
    DIG_SEC_TENS = 3'd3,
    DIG_MIN_ONES = 3'd4,
    DIG_MIN_TENS = 3'd5
  } digit_e;

  digit_e        idx;
  digit_e        idx_nxt;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;
  logic          tick;
  logic [23:0]   snap;
  logic          load_snap;
  logic          first;

  logic [3:0]    nib;
  logic          lz_hide;
  logic [5:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  // BCD digit to active-low {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // ------------------------------------------------------------------------
  // Prescaler and slot sequencing
  // ------------------------------------------------------------------------
  always_comb begin
    tick     = (pcnt == PCNT_LAST);
    pcnt_nxt = tick ? '0 : pcnt + PW'(1);
    idx_nxt  = idx;
    if (tick) begin
      case (idx)
        DIG_MS_ONES:  idx_nxt = DIG_MS_TENS;
        DIG_MS_TENS:  idx_nxt = DIG_SEC_ONES;
        DIG_SEC_ONES: idx_nxt = DIG_SEC_TENS;
        DIG_SEC_TENS: idx_nxt = DIG_MIN_ONES;
        DIG_MIN_ONES: idx_nxt = DIG_MIN_TENS;
        DIG_MIN_TENS: idx_nxt = DIG_MS_ONES;
        default:      idx_nxt = DIG_MS_ONES;
      endcase
    end
    // 'first' covers the cycle right after reset release so the display
    // does not run a whole frame on the cleared snapshot.
    load_snap = first | (tick & (idx == DIG_MIN_TENS));
  end

  // ------------------------------------------------------------------------
  // Output decode, computed from the current pcnt/idx/snap and registered
  // ------------------------------------------------------------------------
  always_comb begin
    case (idx)
      DIG_MS_ONES:  nib = snap[3:0];
      DIG_MS_TENS:  nib = snap[7:4];
      DIG_SEC_ONES: nib = snap[11:8];
      DIG_SEC_TENS: nib = snap[15:12];
      DIG_MIN_ONES: nib = snap[19:16];
      DIG_MIN_TENS: nib = snap[23:20];
      default:      nib = 4'hF;
    endcase

    lz_hide = LZ_BLANK && (idx == DIG_MIN_TENS) && (snap[23:20] == 4'd0);

    an_nxt  = '1;
    seg_nxt = '1;
    dp_nxt  = 1'b1;
    if (disp_en_i) begin
      if (pcnt >= PCNT_BLANK) begin
        an_nxt = ~(6'b000001 << idx);
      end
      // Segments switch at the start of the blank window, so they are
      // already settled when the anode turns on.
      seg_nxt = lz_hide ? 7'h7F : bcd_to_seg(nib);
      dp_nxt  = !((idx == DIG_SEC_ONES) || (idx == DIG_MIN_ONES));
    end
  end

  // ------------------------------------------------------------------------
  // State and output registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk_core) begin
    if (rst) begin
      pcnt    <= '0;
      idx     <= DIG_MS_ONES;
      snap    <= '0;
      first   <= 1'b1;
      an_o    <= '1;
      seg_o   <= '1;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      pcnt    <= pcnt_nxt;
      idx     <= idx_nxt;
      first   <= 1'b0;
      if (load_snap) begin
        snap <= {min_i, sec_i, ms_10_i};
      end
      frame_o <= load_snap;
      an_o    <= an_nxt;
      seg_o   <= seg_nxt;
      dp_o    <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_6.sv
module tb_seg_scan_6;

  localparam int unsigned SD = 4;
  localparam int unsigned BC = 1;

  logic       clk_core = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] min_i, sec_i, ms_10_i;
  logic       disp_en_i;
  logic [5:0] an_o, an_n;
  logic [6:0] seg_o, seg_n;
  logic       dp_o, dp_n, frame_o, frame_n;

  seg_scan_6 #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(1'b1)) dut (
    .clk_core(clk_core), .rst(rst), .min_i(min_i), .sec_i(sec_i),
    .ms_10_i(ms_10_i), .disp_en_i(disp_en_i),
    .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o), .frame_o(frame_o)
  );

  seg_scan_6 #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(1'b0)) dut_nlz (
    .clk_core(clk_core), .rst(rst), .min_i(min_i), .sec_i(sec_i),
    .ms_10_i(ms_10_i), .disp_en_i(disp_en_i),
    .an_o(an_n), .seg_o(seg_n), .dp_o(dp_n), .frame_o(frame_n)
  );

  always #5 clk_core = ~clk_core;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic [6:0] seg_nlz;
    logic       dp;
  } exp_t;

  exp_t q[$];

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  bit          mon_en = 1'b0;

  // Directed vectors: inputs and hand-decoded segments for idx0..idx5.
  logic [7:0] v_min [4] = '{8'h12, 8'h12, 8'h07, 8'h98};
  logic [7:0] v_sec [4] = '{8'h34, 8'h59, 8'h00, 8'h70};
  logic [7:0] v_ms  [4] = '{8'h56, 8'h56, 8'hA3, 8'h81};
  logic [6:0] v_seg [4][6] = '{
    '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79},
    '{7'h02, 7'h12, 7'h10, 7'h12, 7'h24, 7'h79},
    '{7'h30, 7'h3F, 7'h40, 7'h40, 7'h78, 7'h7F},
    '{7'h79, 7'h00, 7'h40, 7'h78, 7'h00, 7'h10}
  };
  logic [6:0] v_idx5_nlz [4] = '{7'h79, 7'h79, 7'h40, 7'h10};
  logic [5:0] an_tab [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic       dp_tab [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input int k);
    min_i   = v_min[k];
    sec_i   = v_sec[k];
    ms_10_i = v_ms[k];
  endtask

  task automatic push_frame(input int k);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.an      = an_tab[i];
      e.seg     = v_seg[k][i];
      e.seg_nlz = (i == 5) ? v_idx5_nlz[k] : v_seg[k][i];
      e.dp      = dp_tab[i];
      q.push_back(e);
    end
  endtask

  task automatic wait_frame(input string tag);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk_core);
      n++;
    end while (frame_o !== 1'b1 && n < 100);
    if (frame_o !== 1'b1) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: frame_o=%b after 100 cycles, expected a pulse", tag, frame_o);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"},    an_o,    6'h3F);
    chk({tag, "_seg"},   seg_o,   7'h7F);
    chk({tag, "_dp"},    dp_o,    1'b1);
    chk({tag, "_frame"}, frame_o, 1'b0);
    chk({tag, "_an_nlz"}, an_n,   6'h3F);
  endtask

  // Monitor: each time an anode lights after a blank, pop the next expected
  // digit; when it goes dark again, check the lit length of the slot.
  logic [5:0]  prev_an = 6'h3F;
  int unsigned lit_cnt = 0;
  bit          live    = 1'b0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_core);
      if (an_o !== 6'h3F && prev_an === 6'h3F) begin
        lit_cnt = 1;
        live    = mon_en;
        if (mon_en) begin
          if (q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_digit: an_o=%h lit, expected no digit", an_o);
          end else begin
            e = q.pop_front();
            chk("an",      an_o,  e.an);
            chk("seg",     seg_o, e.seg);
            chk("dp",      dp_o,  e.dp);
            chk("an_nlz",  an_n,  e.an);
            chk("seg_nlz", seg_n, e.seg_nlz);
          end
        end
      end else if (an_o !== 6'h3F) begin
        lit_cnt++;
      end else if (prev_an !== 6'h3F) begin
        if (live && mon_en) chk("lit_len", lit_cnt, SD - BC);
        live = 1'b0;
      end
      prev_an = an_o;
    end
  end

  initial begin : stim
    disp_en_i = 1'b1;
    apply(0);
    rst = 1'b1;
    repeat (3) @(negedge clk_core);
    chk_reset("reset");

    rst = 1'b0;
    @(negedge clk_core);
    chk("frame_after_release", frame_o, 1'b1);
    chk("frame_after_release_nlz", frame_n, 1'b1);
    push_frame(0);
    #1 mon_en = 1'b1;

    // Change seconds during idx1: current frame keeps 3,4.
    repeat (5) @(negedge clk_core);
    apply(1);
    wait_frame("frame_v1");
    push_frame(1);
    apply(2);
    wait_frame("frame_v2");
    push_frame(2);
    apply(3);
    wait_frame("frame_v3");
    push_frame(3);

    // Display-enable masking and mid-slot reset, timed from a frame pulse.
    wait_frame("frame_dark");
    @(negedge clk_core);
    #1 mon_en = 1'b0;
    @(negedge clk_core);
    @(negedge clk_core);
    chk("an_before_dark", an_o, 6'h3E);
    disp_en_i = 1'b0;
    @(negedge clk_core);
    chk("dark_an",  an_o,  6'h3F);
    chk("dark_seg", seg_o, 7'h7F);
    chk("dark_dp",  dp_o,  1'b1);
    repeat (5) @(negedge clk_core);
    chk("dark_hold_an", an_o, 6'h3F);
    repeat (4) @(negedge clk_core);
    disp_en_i = 1'b1;
    @(negedge clk_core);
    chk("resume_an",    an_o,    6'h37);
    chk("resume_seg",   seg_o,   7'h78);
    chk("resume_dp",    dp_o,    1'b1);
    chk("resume_frame", frame_o, 1'b0);
    rst = 1'b1;
    @(negedge clk_core);
    chk_reset("midslot_reset");

    apply(0);
    @(negedge clk_core);
    rst = 1'b0;
    @(negedge clk_core);
    chk("frame_after_rerelease", frame_o, 1'b1);
    push_frame(0);
    #1 mon_en = 1'b1;
    wait_frame("frame_end");
    @(negedge clk_core);
    #1 mon_en = 1'b0;
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
